// File: rtl/uart_pkg.sv
// Shared definitions for the 16x-oversampling UART receiver.
//   rx_state_e     : receiver FSM states
//   OVERSAMPLE_DEF : default baud_tick pulses per bit period
//   DATA_BITS_DEF  : default payload bits per frame
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
//   clk, rst  : system clock, asynchronous active-high reset
//   serial_in : raw line input (idle high)
//   rxs       : synchronized line value; both flops reset to the idle level
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  output logic rxs
);

  logic meta_q;
  logic rxs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      meta_q <= serial_in;
      rxs_q  <= meta_q;
    end
  end

  assign rxs = rxs_q;

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x-oversampling UART receiver with a single-entry valid/ready holding
// register. Samples each bit at mid-bit using the baud_tick strobe.
//   clk, rst    : system clock, asynchronous active-high reset
//   baud_tick   : one-clk pulse at OVERSAMPLE x baud rate
//   serial_in   : asynchronous line input, idle high
//   rx_data     : received word, valid while rx_valid
//   rx_valid    : holding register full
//   rx_ready    : consumer accepts rx_data when rx_valid && rx_ready
//   busy        : FSM not idle
//   frame_err   : one-clk pulse, stop bit sampled low
//   parity_err  : one-clk pulse, parity mismatch
//   overrun_err : one-clk pulse, good frame arrived while holding register full
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic              ODD       = 1'(PARITY_ODD != 0);

  logic rxs;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .rxs       (rxs)
  );

  rx_state_e            state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_err_q, overrun_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      tick_q        <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      par_bad_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      par_bad_q     <= par_bad_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      parity_err_q  <= parity_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  // A full bit period has elapsed on this tick (DATA/PARITY/STOP sample point).
  logic bit_end;
  assign bit_end = baud_tick && (tick_q == TICK_LAST);

  always_comb begin
    state_d       = state_q;
    tick_d        = tick_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    par_bad_d     = par_bad_q;
    rx_data_d     = rx_data_q;
    // A consumer handshake empties the register unless a load overrides below.
    rx_valid_d    = rx_valid_q && !rx_ready;
    frame_err_d   = 1'b0;
    parity_err_d  = 1'b0;
    overrun_err_d = 1'b0;

    // Bit-period counter shared by the DATA/PARITY/STOP states.
    if (baud_tick && (state_q == DATA || state_q == PARITY || state_q == STOP)) begin
      tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        if (baud_tick && !rxs) begin
          state_d   = START;
          par_bad_d = 1'b0;
        end
      end
      START: begin
        // Re-check the line half a bit after the falling edge to reject glitches.
        if (baud_tick) begin
          if (tick_q == TICK_MID) begin
            tick_d  = '0;
            state_d = rxs ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          par_bad_d = rxs ^ (^shift_q) ^ ODD;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          if (!rxs) begin
            frame_err_d = 1'b1;
          end else if (par_bad_q) begin
            parity_err_d = 1'b1;
          end else if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            overrun_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = (state_q != IDLE);
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench for uart_rx_oversample: directed scenarios plus a
// randomized frame stream scored against a frame-level holding-register model.
module tb_uart_rx_oversample;

  localparam int CLKS_PER_TICK = 4;
  localparam int CLKS_PER_BIT  = 16 * CLKS_PER_TICK;

  logic       clk, rst, baud_tick, rx_ready;
  logic       ser, ser_p;
  logic [7:0] rx_data, p_data;
  logic       rx_valid, busy, frame_err, parity_err, overrun_err;
  logic       p_valid, p_busy, p_frame_err, p_parity_err, p_overrun_err;

  uart_rx_oversample #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .serial_in(ser),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .busy(busy),
    .frame_err(frame_err), .parity_err(parity_err), .overrun_err(overrun_err)
  );

  uart_rx_oversample #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .serial_in(ser_p),
    .rx_data(p_data), .rx_valid(p_valid), .rx_ready(rx_ready), .busy(p_busy),
    .frame_err(p_frame_err), .parity_err(p_parity_err), .overrun_err(p_overrun_err)
  );

  int checks = 0;
  int errors = 0;

  // Event counters filled by the monitor, cleared by the stimulus between scenarios.
  int n_ferr, n_perr, n_ovr, busy_cyc, valid_cyc;
  int p_ferr, p_perr, p_ovr;
  logic [7:0] got_q[$];
  logic [7:0] pgot_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int div;
    div = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      div = div + 1;
      baud_tick = (div % CLKS_PER_TICK) == 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err)    n_ferr++;
      if (parity_err)   n_perr++;
      if (overrun_err)  n_ovr++;
      if (busy)         busy_cyc++;
      if (rx_valid)     valid_cyc++;
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (p_frame_err)  p_ferr++;
      if (p_parity_err) p_perr++;
      if (p_overrun_err) p_ovr++;
      if (p_valid && rx_ready) pgot_q.push_back(p_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_counts();
    n_ferr = 0; n_perr = 0; n_ovr = 0; busy_cyc = 0; valid_cyc = 0;
    p_ferr = 0; p_perr = 0; p_ovr = 0;
    got_q.delete();
    pgot_q.delete();
  endtask

  task automatic send_bit(input logic b);
    ser = b;
    wait_clks(CLKS_PER_BIT);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    ser = 1'b1;
  endtask

  task automatic send_pframe(input logic [7:0] d, input logic pbit);
    logic [9:0] bits;
    bits = {pbit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ser_p = bits[i];
      wait_clks(CLKS_PER_BIT);
    end
    ser_p = 1'b1;
    wait_clks(CLKS_PER_BIT);
  endtask

  function automatic logic [31:0] pop_got();
    return (got_q.size() > 0) ? {24'd0, got_q.pop_front()} : 32'hxxxxxxxx;
  endfunction

  initial begin
    logic [7:0] exp_q[$];
    logic       mdl_valid;
    logic [7:0] mdl_data;
    int         exp_ferr, exp_ovr;
    logic [7:0] d;
    logic       stop_ok, rdy;

    rst = 1'b1; ser = 1'b1; ser_p = 1'b1; rx_ready = 1'b0;
    clear_counts();
    wait_clks(5);
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 0);
    check("reset_busy", busy, 0);
    check("reset_errs", {frame_err, parity_err, overrun_err}, 0);
    rst = 1'b0;
    wait_clks(20);

    // Single good frame, consumer always ready.
    clear_counts();
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    wait_clks(2 * CLKS_PER_BIT);
    check("a5_count", got_q.size(), 1);
    check("a5_data", pop_got(), 8'hA5);
    check("a5_valid_cycles", valid_cyc, 1);
    check("a5_errs", n_ferr + n_perr + n_ovr, 0);
    check("a5_busy_cycles", busy_cyc, 152 * CLKS_PER_TICK);

    // Back-to-back frames with the consumer stalled: second one overruns.
    clear_counts();
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    wait_clks(CLKS_PER_BIT);
    check("ovr_valid_held", rx_valid, 1);
    check("ovr_data_held", rx_data, 8'h3C);
    check("ovr_pulses", n_ovr, 1);
    check("ovr_nothing_taken", got_q.size(), 0);
    rx_ready = 1'b1;
    wait_clks(1);
    check("ovr_valid_drop", rx_valid, 0);
    check("ovr_handshake_data", pop_got(), 8'h3C);

    // Bad stop bit, then a good frame.
    clear_counts();
    send_frame(8'h55, 1'b0);
    wait_clks(3 * CLKS_PER_BIT);
    check("ferr_pulses", n_ferr, 1);
    check("ferr_no_valid", valid_cyc, 0);
    clear_counts();
    send_frame(8'h12, 1'b1);
    wait_clks(2 * CLKS_PER_BIT);
    check("after_ferr_data", pop_got(), 8'h12);
    check("after_ferr_errs", n_ferr + n_perr + n_ovr, 0);

    // Short low glitch on an idle line: START aborts after half a bit.
    clear_counts();
    ser = 1'b0;
    wait_clks(3 * CLKS_PER_TICK);
    ser = 1'b1;
    wait_clks(2 * CLKS_PER_BIT);
    check("glitch_busy_cycles", busy_cyc, 8 * CLKS_PER_TICK);
    check("glitch_no_events", n_ferr + n_perr + n_ovr + valid_cyc, 0);

    // Even parity: 0x07 has three ones, so the correct parity bit is 1.
    clear_counts();
    send_pframe(8'h07, 1'b0);
    wait_clks(CLKS_PER_BIT);
    check("par_bad_pulse", p_perr, 1);
    check("par_bad_no_data", pgot_q.size(), 0);
    clear_counts();
    send_pframe(8'h07, 1'b1);
    wait_clks(CLKS_PER_BIT);
    check("par_ok_count", pgot_q.size(), 1);
    check("par_ok_data", (pgot_q.size() > 0) ? pgot_q.pop_front() : 8'hxx, 8'h07);
    check("par_ok_errs", p_perr + p_ferr + p_ovr, 0);

    // Reset in the middle of the data bits of 0xFF.
    clear_counts();
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", rx_valid, 0);
    check("midrst_data", rx_data, 0);
    wait_clks(3);
    rst = 1'b0;
    for (int i = 3; i < 8; i++) send_bit(1'b1);
    send_bit(1'b1);
    wait_clks(CLKS_PER_BIT);
    check("midrst_no_output", got_q.size() + n_ferr + n_perr + n_ovr, 0);
    send_frame(8'h81, 1'b1);
    wait_clks(2 * CLKS_PER_BIT);
    check("after_rst_data", pop_got(), 8'h81);

    // Random frames: the model tracks the holding register per frame.
    clear_counts();
    mdl_valid = 1'b0; mdl_data = 8'h00; exp_ferr = 0; exp_ovr = 0;
    for (int f = 0; f < 14; f++) begin
      d       = 8'($urandom);
      stop_ok = ($urandom_range(0, 4) != 0);
      rdy     = 1'($urandom_range(0, 1));
      rx_ready = rdy;
      if (rdy && mdl_valid) begin
        exp_q.push_back(mdl_data);
        mdl_valid = 1'b0;
      end
      send_frame(d, stop_ok);
      if (!stop_ok) exp_ferr++;
      else if (rdy) exp_q.push_back(d);
      else if (!mdl_valid) begin
        mdl_valid = 1'b1;
        mdl_data  = d;
      end else exp_ovr++;
      wait_clks(2 * CLKS_PER_BIT);
    end
    rx_ready = 1'b1;
    if (mdl_valid) exp_q.push_back(mdl_data);
    wait_clks(4);
    check("rand_ferr", n_ferr, exp_ferr);
    check("rand_ovr", n_ovr, exp_ovr);
    check("rand_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0) check("rand_data", pop_got(), {24'd0, exp_q.pop_front()});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversample.md
Name: uart_rx_oversample

Overview:
- 16x-oversampling UART receiver; the receive end for frames produced by the team's 8N1 transmitter.
- Driven by the baud generator's one-clk 16x tick. Samples each bit at mid-bit, validates start and stop bits, optionally checks parity.
- Delivers bytes through a single-entry valid/ready holding register and flags framing, parity and overrun errors.
- Sits between the serial_in pad and any byte consumer (TX loopback, FIFO, control logic).

Parameters:
- DATA_BITS, 8, payload bits per frame, LSB first (5..9 legal).
- OVERSAMPLE, 16, baud_tick pulses per bit period (even, >=4).
- PARITY_EN, 0, 1 = one parity bit follows the data bits.
- PARITY_ODD, 0, when PARITY_EN=1: 0 = even parity, 1 = odd parity.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- baud_tick  in  1  one-clk-wide pulse at OVERSAMPLE x baud rate.
- serial_in  in  1  asynchronous line input; idle high.
- rx_data  out  DATA_BITS  received byte; valid while rx_valid=1.
- rx_valid  out  1  holding register full.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready on a clk edge.
- busy  out  1  high whenever the FSM is not IDLE.
- frame_err  out  1  one-clk pulse: stop bit sampled low.
- parity_err  out  1  one-clk pulse: parity mismatch.
- overrun_err  out  1  one-clk pulse: good frame completed while holding register full.

Behaviour:
- Reset: asynchronous and active-high.
  - Reset values: FSM=IDLE, sync flops=1, rx_data=0, rx_valid=0, busy=0, all error pulses=0, tick counter=0, bit counter=0.
  - Reset mid-frame aborts the frame. No output is produced afterwards for the partial frame.
- Input path: serial_in passes through a 2-flop synchronizer. All decisions use the synchronized value rxs. The 2-clk delay is part of latency.
- FSM states:
  - IDLE -> START: on a baud_tick with rxs=0. Tick counter cleared.
  - START: count ticks. At tick OVERSAMPLE/2 (the 8th tick), sample rxs.
    - rxs=0: go to DATA, tick counter cleared.
    - rxs=1: glitch; return to IDLE with no error.
  - DATA: every OVERSAMPLE ticks, sample rxs into the shift register MSB, shifting right (LSB first). After DATA_BITS samples, go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: sample after OVERSAMPLE ticks. Compare with the XOR of the data bits XOR PARITY_ODD. Record mismatch internally. Go to STOP.
  - STOP: sample after OVERSAMPLE ticks, then take exactly one action and return to IDLE in the same cycle:
    - rxs=0: frame_err pulses; frame discarded.
    - else parity mismatch: parity_err pulses; frame discarded.
    - else rx_valid=0, or rx_ready=1 in this same cycle: load rx_data, rx_valid=1.
    - else: overrun_err pulses; new byte dropped; old rx_data and rx_valid unchanged.
- Latency: rx_data/rx_valid update on the clk edge following the baud_tick that samples the stop bit.
- Timing: no new start bit is accepted until the tick after returning to IDLE. This gives half-bit stop slack, so back-to-back frames at nominal rate are received.
- Handshake: rx_valid falls on the edge where rx_valid && rx_ready, unless a new frame loads in that same cycle, in which case rx_valid stays 1 with the new data.
- Ticks: baud_tick is ignored outside its pulse. The counters advance only on ticks.
- busy: combinational, (state != IDLE).
- Widths:
  - tick counter: clog2(OVERSAMPLE) bits, wraps to 0 at OVERSAMPLE-1.
  - bit counter: clog2(DATA_BITS+1) bits.

Decomposition:
- uart_pkg holds: rx state enum (IDLE, START, DATA, PARITY, STOP) and the default constants OVERSAMPLE_DEF=16, DATA_BITS_DEF=8.
- One sub-module, uart_rx_sync: 2-flop synchronizer with reset-to-1, output rxs.

Test Plan:
- Bench drives baud_tick every 4 clks (bit = 64 clks).
- Send 8N1 byte 0xA5, rx_ready=1 → rx_valid pulses one clk with rx_data=0xA5; no error pulses; busy high for about 9.5 bit periods.
- 0x3C then 0xC3 back-to-back, rx_ready=0 until after the second stop → rx_data=0x3C retained, overrun_err pulses once, then handshake returns 0x3C.
- Frame 0x55 with stop bit forced 0 → frame_err pulse, rx_valid stays 0, next good frame 0x12 received correctly.
- 0-pulse of 3 ticks on idle line → FSM returns to IDLE from START, no outputs, busy high for about 8 ticks only.
- PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity bit 0 (wrong) → parity_err pulse, no rx_valid; with parity bit 1 → rx_data=0x07.
- Assert rst mid-DATA of 0xFF → all outputs at reset values immediately; following frame 0x81 received correctly.
